// File: rtl/fft_ctrl_pkg.sv
// Shared constants and state encoding for the FFT front-end control blocks.
package fft_ctrl_pkg;

  localparam int BEATS_PER_FRAME = 32;
  localparam int LANES           = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ERR   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ctrl_mod10_rx.sv
// Module-10 receive control: turns alert/valid beat handshakes into reorder-buffer
// writes, counts beats per frame and launches the module-10 butterfly stage.
//
// state    | meaning
// ST_IDLE  | waiting for alert_mod10; a valid here is a protocol violation
// ST_ARMED | alert seen, valid_fac8_0 must arrive this cycle
// ST_ERR   | violation latched, inputs ignored until clr_err
module ctrl_mod10_rx
  import fft_ctrl_pkg::*;
#(
  parameter int BEATS = BEATS_PER_FRAME,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          alert_mod10,
  input  logic          valid_fac8_0,
  input  logic          clr_err,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          frame_done,
  output logic          bf_en_mod10,
  output logic [7:0]    frame_cnt,
  output logic          proto_err,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);

  rx_state_t     state, state_nxt;
  logic [AW-1:0] beat_cnt, beat_cnt_nxt;
  logic          accept;
  logic          viol;
  logic          last_q;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    accept       = 1'b0;
    viol         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (valid_fac8_0) begin
          viol      = 1'b1;
          state_nxt = ST_ERR;
        end else if (alert_mod10) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (valid_fac8_0) begin
          accept    = 1'b1;
          state_nxt = alert_mod10 ? ST_ARMED : ST_IDLE;
        end else begin
          viol      = 1'b1;
          state_nxt = ST_ERR;
        end
      end
      ST_ERR: begin
        if (clr_err) begin
          state_nxt    = ST_IDLE;
          beat_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (accept) begin
      beat_cnt_nxt = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + AW'(1);
    end
  end

  // last_q -> frame_done -> bf_en_mod10; a violation kills whatever is still in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      last_q      <= 1'b0;
      frame_done  <= 1'b0;
      bf_en_mod10 <= 1'b0;
      frame_cnt   <= '0;
      proto_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat_cnt    <= beat_cnt_nxt;
      wr_en       <= accept;
      if (accept) begin
        wr_addr <= beat_cnt;
      end
      last_q      <= accept && (beat_cnt == LAST_BEAT);
      frame_done  <= last_q && !viol;
      bf_en_mod10 <= frame_done && !viol;
      if (last_q && !viol) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      proto_err   <= (state_nxt == ST_ERR);
      busy        <= (beat_cnt_nxt != '0) || (state_nxt == ST_ARMED);
    end
  end

endmodule

// File: tb/tb_ctrl_mod10_rx.sv
// Scoreboard bench for ctrl_mod10_rx: directed beat sequences push expected writes
// and frame completions; a monitor pops and compares whenever the DUT pulses.
module tb_ctrl_mod10_rx;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          alert_mod10 = 1'b0;
  logic          valid_fac8_0 = 1'b0;
  logic          clr_err = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          frame_done;
  logic          bf_en_mod10;
  logic [7:0]    frame_cnt;
  logic          proto_err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  int exp_addr_q[$];
  int exp_frame_q[$];
  int exp_beat   = 0;
  int exp_frames = 0;
  int fd_seen    = 0;
  int bf_seen    = 0;
  logic prev_fd  = 1'b0;

  ctrl_mod10_rx #(.BEATS(32), .AW(AW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .alert_mod10  (alert_mod10),
    .valid_fac8_0 (valid_fac8_0),
    .clr_err      (clr_err),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .frame_done   (frame_done),
    .bf_en_mod10  (bf_en_mod10),
    .frame_cnt    (frame_cnt),
    .proto_err    (proto_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      if (exp_addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got wr_addr %0d expected no write at %0t", wr_addr, $time);
      end else begin
        chk("wr_addr", int'(wr_addr), exp_addr_q.pop_front());
      end
    end
    if (frame_done) begin
      fd_seen++;
      chk("frame_done_width", int'(prev_fd), 0);
      if (exp_frame_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_done_unexpected: got frame_cnt %0d expected no pulse at %0t", frame_cnt, $time);
      end else begin
        chk("frame_cnt_at_done", int'(frame_cnt), exp_frame_q.pop_front());
      end
    end
    if (bf_en_mod10) bf_seen++;
    if (prev_fd || bf_en_mod10) chk("bf_en_timing", int'(bf_en_mod10), int'(prev_fd));
    prev_fd = frame_done;
  end

  task automatic cyc(input logic a, input logic v, input logic c);
    @(negedge clk);
    alert_mod10  = a;
    valid_fac8_0 = v;
    clr_err      = c;
  endtask

  task automatic push_beat(input bit frame_ok);
    exp_addr_q.push_back(exp_beat);
    if (exp_beat == 31 && frame_ok) begin
      exp_frames = (exp_frames + 1) % 256;
      exp_frame_q.push_back(exp_frames);
    end
    exp_beat = (exp_beat + 1) % 32;
  endtask

  // alert, valid, idle: the 3-cycle beat pattern
  task automatic beat();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    push_beat(1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    int bf0;

    // reset values
    idle(3);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_bf_en", int'(bf_en_mod10), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_proto_err", int'(proto_err), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // single beat
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    push_beat(1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("single_busy", int'(busy), 1);
    chk("single_no_done", int'(frame_done), 0);

    // rest of a spaced frame
    for (int i = 1; i < 32; i++) beat();
    idle(4);
    chk("frame_cnt_1", int'(frame_cnt), 1);
    chk("frame_busy_0", int'(busy), 0);
    chk("frame_bf_count", bf_seen, 1);

    // back-to-back frame
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cyc((i < 31) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      push_beat(1'b1);
    end
    idle(4);
    chk("b2b_frame_cnt", int'(frame_cnt), 2);
    chk("b2b_busy", int'(busy), 0);
    chk("b2b_bf_count", bf_seen, 2);

    // clr_err outside ERR is ignored; counter keeps going
    beat();
    beat();
    beat();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_idle_proto", int'(proto_err), 0);
    beat();

    // missing valid mid-frame
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("miss_proto_err", int'(proto_err), 1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("err_sticky", int'(proto_err), 1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_proto_err", int'(proto_err), 0);
    chk("clr_busy", int'(busy), 0);
    exp_beat = 0;
    beat();

    // orphan valid at beat 10
    for (int i = 1; i < 10; i++) beat();
    fd0 = fd_seen;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    idle(3);
    chk("orphan_proto_err", int'(proto_err), 1);
    chk("orphan_frame_cnt", int'(frame_cnt), 2);
    chk("orphan_no_done", fd_seen, fd0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    exp_beat = 0;

    // violation right after the last beat cancels frame_done/bf_en
    for (int i = 0; i < 31; i++) beat();
    fd0 = fd_seen;
    bf0 = bf_seen;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    push_beat(1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    idle(4);
    chk("cancel_proto_err", int'(proto_err), 1);
    chk("cancel_no_done", fd_seen, fd0);
    chk("cancel_no_bf", bf_seen, bf0);
    chk("cancel_frame_cnt", int'(frame_cnt), 2);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    exp_beat = 0;

    // reset mid-frame after beat 20
    for (int i = 0; i <= 20; i++) beat();
    idle(1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_wr_addr", int'(wr_addr), 0);
    chk("mid_rst_frame_cnt", int'(frame_cnt), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_proto_err", int'(proto_err), 0);
    exp_beat   = 0;
    exp_frames = 0;
    idle(2);
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
    beat();
    idle(2);
    chk("post_rst_frame_cnt", int'(frame_cnt), 0);
    chk("post_rst_busy", int'(busy), 1);

    idle(4);
    chk("addr_queue_empty", exp_addr_q.size(), 0);
    chk("frame_queue_empty", exp_frame_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
